// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   ARM register file for the single-cycle datapath. It holds fifteen
//   physical registers, R0..R14. Address 15 is not stored here: reads of
//   address 15 return the PC+8 value supplied on r15.
//
//   The register file sits downstream of the result-select mux, which drives
//   wd3. Writes take effect on the rising edge of clk. The file also performs
//   the BL link write into R14, raises an error pulse when a normal write
//   targets R15, and provides a third read port for debug.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; clears R0..R14 and wr15_err
//   ra1/ra2   combinational read addresses (Rn, Rm/Rd-for-STR)
//   rd1/rd2   read data; address 15 returns r15
//   we3       normal result write enable
//   wa3       normal result write address
//   wd3       normal result write data
//   link_we   BL link write: R14 <= r15 - 4
//   r15       PC+8 from the PC adder
//   wr15_err  one-cycle registered pulse after a we3 write aimed at R15
//   dbg_addr  debug read address
//   dbg_data  debug read data, same mapping as rd1/rd2
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int W    = 32,
  parameter int NREG = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   ra1,
  input  logic [3:0]   ra2,
  output logic [W-1:0] rd1,
  output logic [W-1:0] rd2,
  input  logic         we3,
  input  logic [3:0]   wa3,
  input  logic [W-1:0] wd3,
  input  logic         link_we,
  input  logic [W-1:0] r15,
  output logic         wr15_err,
  input  logic [3:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  localparam logic [3:0] PcAddr   = 4'd15;
  localparam int         LinkIdx  = 14;
  localparam logic [W-1:0] LinkOffset = W'(4);

  logic [W-1:0] regs_q [NREG];
  logic [W-1:0] regs_d [NREG];
  logic         wr15Err_q;
  logic         wr15Err_d;
  logic [W-1:0] linkAddr;
  logic         pcWriteAttempt;

  // The return address for BL is PC+4. r15 already carries PC+8, so we
  // subtract 4. The subtraction wraps modulo 2^W, which means r15 = 0 yields
  // all-ones minus 3.
  assign linkAddr       = r15 - LinkOffset;
  assign pcWriteAttempt = we3 && (wa3 == PcAddr);

  // Next-state for the register array. Every register holds by default.
  // The normal result write is applied first and the link write last, so
  // that when both target R14 the link value overrides wd3. A write to
  // address 15 matches no physical register and is therefore dropped here.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int i = 0; i < NREG; i++) begin
      if (we3 && (wa3 == 4'(i))) begin
        regs_d[i] = wd3;
      end
    end
    if (link_we) begin
      regs_d[LinkIdx] = linkAddr;
    end
  end

  // The error flag is recomputed on every edge. It is therefore high for
  // exactly one cycle per R15 write attempt and low otherwise.
  always_comb begin
    wr15Err_d = pcWriteAttempt;
  end

  // State registers. Reset is asynchronous, so a reset asserted mid-cycle
  // clears the array immediately, and any write pending for the next edge
  // is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr15Err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr15Err_q <= wr15Err_d;
    end
  end

  // Read ports are purely combinational and read the registered state only.
  // A value written at an edge therefore becomes visible after that edge,
  // never in the same cycle, which matches single-cycle CPU semantics.
  always_comb begin
    rd1      = r15;
    rd2      = r15;
    dbg_data = r15;
    for (int i = 0; i < NREG; i++) begin
      if (ra1 == 4'(i)) begin
        rd1 = regs_q[i];
      end
      if (ra2 == 4'(i)) begin
        rd2 = regs_q[i];
      end
      if (dbg_addr == 4'(i)) begin
        dbg_data = regs_q[i];
      end
    end
  end

  assign wr15_err = wr15Err_q;

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Directed bench for reg_file. Each expected value is pushed onto a
//   scoreboard queue when the stimulus that produces it is applied. The
//   expected value is popped and compared against the DUT output once that
//   output is due.
// ---------------------------------------------------------------------------
module tb_reg_file;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   ra1, ra2, wa3, dbg_addr;
  logic [W-1:0] rd1, rd2, wd3, r15, dbg_data;
  logic         we3, link_we, wr15_err;

  typedef struct {
    string        tag;
    logic [W-1:0] value;
  } expect_t;

  expect_t scoreboard[$];
  int nAssert = 0;
  int nFail   = 0;

  reg_file #(.W(W), .NREG(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .link_we(link_we), .r15(r15), .wr15_err(wr15_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Drive the write-side inputs in one step.
  task automatic applyStimulus(input logic iWe, input logic [3:0] iWa,
                               input logic [W-1:0] iWd, input logic iLink,
                               input logic [W-1:0] iR15);
    we3     = iWe;
    wa3     = iWa;
    wd3     = iWd;
    link_we = iLink;
    r15     = iR15;
  endtask

  // Queue up the value the next checkOutput call must see.
  task automatic expectValue(input string tag, input logic [W-1:0] value);
    expect_t e;
    e.tag   = tag;
    e.value = value;
    scoreboard.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the observed DUT value.
  task automatic checkOutput(input logic [W-1:0] observed);
    expect_t e;
    nAssert++;
    if (scoreboard.size() == 0) begin
      nFail++;
      $error("[TB] FAIL scoreboard_empty: observed %h expected <none>", observed);
    end else begin
      e = scoreboard.pop_front();
      assert (observed === e.value)
      else begin
        nFail++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, observed, e.value);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ra1 = 4'd0; ra2 = 4'd0; dbg_addr = 4'd0;
    applyStimulus(1'b0, 4'd0, '0, 1'b0, 32'h100);

    // Reset state: R0..R14 read 0 and address 15 reads r15.
    #2;
    for (int a = 0; a < 16; a++) begin
      ra1 = 4'(a); ra2 = 4'(15 - a); dbg_addr = 4'(a);
      #1;
      expectValue($sformatf("reset_rd1_a%0d", a), (a == 15) ? 32'h100 : 32'h0);
      checkOutput(rd1);
      expectValue($sformatf("reset_rd2_a%0d", 15 - a), (a == 0) ? 32'h100 : 32'h0);
      checkOutput(rd2);
      expectValue($sformatf("reset_dbg_a%0d", a), (a == 15) ? 32'h100 : 32'h0);
      checkOutput(dbg_data);
    end
    expectValue("reset_wr15_err", 32'h0);
    checkOutput({31'b0, wr15_err});

    @(negedge clk);
    rst_n = 1'b1;

    // Write R3 and confirm it is visible only after the edge.
    @(negedge clk);
    applyStimulus(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 32'h100);
    ra1 = 4'd3;
    #1;
    expectValue("r3_before_edge", 32'h0);
    checkOutput(rd1);
    @(posedge clk); #1;
    expectValue("r3_after_edge", 32'hDEADBEEF);
    checkOutput(rd1);

    // A write to R15 changes no register and pulses wr15_err for one cycle.
    @(negedge clk);
    applyStimulus(1'b1, 4'd15, 32'h1234, 1'b0, 32'h100);
    ra1 = 4'd15; ra2 = 4'd3;
    @(posedge clk); #1;
    expectValue("wr15_err_high", 32'h1);
    checkOutput({31'b0, wr15_err});
    expectValue("r15_reads_pc", 32'h100);
    checkOutput(rd1);
    expectValue("r3_untouched", 32'hDEADBEEF);
    checkOutput(rd2);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, '0, 1'b0, 32'h100);
    @(posedge clk); #1;
    expectValue("wr15_err_low", 32'h0);
    checkOutput({31'b0, wr15_err});
    for (int a = 0; a < 15; a++) begin
      dbg_addr = 4'(a);
      #1;
      expectValue($sformatf("after_r15_write_r%0d", a), (a == 3) ? 32'hDEADBEEF : 32'h0);
      checkOutput(dbg_data);
    end

    // Link write and a wd3 write both target R14: the link value wins.
    @(negedge clk);
    applyStimulus(1'b1, 4'd14, 32'h55, 1'b1, 32'h208);
    ra1 = 4'd14;
    @(posedge clk); #1;
    expectValue("link_wins_r14", 32'h204);
    checkOutput(rd1);
    expectValue("link_no_err", 32'h0);
    checkOutput({31'b0, wr15_err});

    // Link write and an R2 write occur on the same edge.
    @(negedge clk);
    applyStimulus(1'b1, 4'd2, 32'h55, 1'b1, 32'h308);
    ra1 = 4'd14; ra2 = 4'd2;
    @(posedge clk); #1;
    expectValue("dual_r14", 32'h304);
    checkOutput(rd1);
    expectValue("dual_r2", 32'h55);
    checkOutput(rd2);

    // With both write enables low, every register holds across an edge.
    @(negedge clk);
    applyStimulus(1'b0, 4'd2, 32'h0, 1'b0, 32'h500);
    @(posedge clk); #1;
    expectValue("hold_r14", 32'h304);
    checkOutput(rd1);
    expectValue("hold_r2", 32'h55);
    checkOutput(rd2);

    // An all-ones write is stored exactly.
    @(negedge clk);
    applyStimulus(1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 32'h500);
    ra1 = 4'd0;
    @(posedge clk); #1;
    expectValue("all_ones_r0", 32'hFFFFFFFF);
    checkOutput(rd1);

    // Write R7, then assert reset mid-cycle: R7 clears before any edge, and
    // the write pending across the reset edge is lost.
    @(negedge clk);
    applyStimulus(1'b1, 4'd7, 32'hA5A5A5A5, 1'b0, 32'h500);
    ra2 = 4'd7;
    @(posedge clk); #1;
    expectValue("r7_written", 32'hA5A5A5A5);
    checkOutput(rd2);
    applyStimulus(1'b1, 4'd5, 32'h77, 1'b0, 32'h500);
    #2;
    rst_n = 1'b0;
    #1;
    expectValue("r7_async_clear", 32'h0);
    checkOutput(rd2);
    @(posedge clk); #1;
    ra1 = 4'd5;
    #1;
    expectValue("r5_write_lost", 32'h0);
    checkOutput(rd1);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, '0, 1'b0, 32'h500);
    rst_n = 1'b1;

    // Link write with r15 = 0 wraps modulo 2^W.
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, '0, 1'b1, 32'h0);
    ra1 = 4'd14;
    @(posedge clk); #1;
    expectValue("link_wrap", 32'hFFFFFFFC);
    checkOutput(rd1);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, '0, 1'b0, 32'h0);

    nAssert++;
    assert (scoreboard.size() == 0)
    else begin
      nFail++;
      $error("[TB] FAIL scoreboard_drained: observed %0d expected 0", scoreboard.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
